// File: rtl/mat_stream_framer_if.sv
// AXI-Stream style bundle used by the matrix stream framer on both its raw
// input side and its framed output side.
interface mat_stream_framer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/mat_stream_framer.sv
// Frames a raw DMA stream into matrix A then matrix B for the multiplier, then waits for the result.
// Optional input-tlast consistency checking is enabled with `define MAT_FRAMER_TLAST_CHECK_EN.
module mat_stream_framer #(
    parameter int DIM_LOG    = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       s00_axi_aclk,
    input  logic                       s00_axi_areset,
    mat_stream_framer_if.slave         s00_axis,
    mat_stream_framer_if.master        m00_axis,
    output logic                       sel,
    output logic                       start,
    input  logic                       res_tvalid,
    input  logic                       res_tready,
    input  logic                       res_tlast,
    output logic                       busy,
    output logic                       err_tlast,
    output logic [7:0]                 err_cnt
);
    localparam int SIZE_LOG = 2 * DIM_LOG;
    localparam logic [SIZE_LOG-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, START, WAIT_RES} state_t;

    state_t                state;
    logic                  in_rdy_q;
    logic [1:0]            occ;
    logic [SIZE_LOG-1:0]   word_cnt;
    logic [DATA_WIDTH-1:0] buf_data_p0;
    logic [DATA_WIDTH-1:0] buf_data_p1;
    logic                  loading;
    logic                  in_hs;
    logic                  out_hs;
    logic                  last_word;

    // in_rdy_q keeps the input closed while reset is held and opens it on the first edge after.
    assign loading         = (state == LOAD_A) || (state == LOAD_B);
    assign s00_axis.tready = in_rdy_q && loading && (occ != 2'd2);
    assign m00_axis.tvalid = loading && (occ != 2'd0);
    assign m00_axis.tdata  = buf_data_p0;
    assign last_word       = (word_cnt == LAST_IDX);
    assign m00_axis.tlast  = m00_axis.tvalid && last_word;
    assign in_hs           = s00_axis.tvalid && s00_axis.tready;
    assign out_hs          = m00_axis.tvalid && m00_axis.tready;

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            state    <= LOAD_A;
            in_rdy_q <= 1'b0;
            occ      <= 2'd0;
            word_cnt <= '0;
            sel      <= 1'b0;
            start    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            in_rdy_q <= 1'b1;
            start    <= 1'b0;
            if (in_hs && !out_hs)
                occ <= occ + 2'd1;
            else if (!in_hs && out_hs)
                occ <= occ - 2'd1;
            if (out_hs)
                word_cnt <= word_cnt + 1'b1;
            case (state)
                LOAD_A: if (out_hs && last_word) begin
                    state <= LOAD_B;
                    sel   <= 1'b1;
                    busy  <= 1'b1;
                end
                LOAD_B: if (out_hs && last_word) begin
                    state <= START;
                    start <= 1'b1;
                end
                START: state <= WAIT_RES;
                WAIT_RES: if (res_tvalid && res_tready && res_tlast) begin
                    state <= LOAD_A;
                    sel   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    // Skid storage: p0 is always the head word; p1 only fills when the head is stalled.
    always_ff @(posedge s00_axi_aclk) begin
        if (out_hs)
            buf_data_p0 <= in_hs ? s00_axis.tdata : buf_data_p1;
        else if (in_hs && occ == 2'd0)
            buf_data_p0 <= s00_axis.tdata;
        if (in_hs && !out_hs && occ == 2'd1)
            buf_data_p1 <= s00_axis.tdata;
    end

`ifdef MAT_FRAMER_TLAST_CHECK_EN
    logic buf_last_p0;
    logic buf_last_p1;
    logic mismatch;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge s00_axi_aclk) begin
        if (out_hs)
            buf_last_p0 <= in_hs ? s00_axis.tlast : buf_last_p1;
        else if (in_hs && occ == 2'd0)
            buf_last_p0 <= s00_axis.tlast;
        if (in_hs && !out_hs && occ == 2'd1)
            buf_last_p1 <= s00_axis.tlast;
    end

    // Checked against the framing counter as each word leaves; the counter never resyncs.
    assign mismatch = out_hs && (buf_last_p0 != last_word);

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            err_tlast <= 1'b0;
            err_cnt   <= 8'd0;
        end else if (mismatch) begin
            err_tlast <= 1'b1;
            err_cnt   <= sat_inc8(err_cnt);
        end
    end
`else
    logic unused_in_tlast;
    assign unused_in_tlast = s00_axis.tlast;
    assign err_tlast       = 1'b0;
    assign err_cnt         = 8'd0;
`endif
endmodule

// File: doc/mat_stream_framer.md
MAT_STREAM_FRAMER -- requirements
Module: mat_stream_framer

Interface
REQ-001 SHALL have parameter DIM_LOG, default 6, meaning matrix dimension in log2 (DIM=2**DIM_LOG, SIZE=DIM*DIM).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning stream word width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: s00_axi_aclk  in  1  sole clock; s00_axi_areset  in  1  asynchronous active-high reset.
REQ-004 SHALL have the ports s00_axis_tvalid  in  1, s00_axis_tready  out  1, s00_axis_tdata  in  DATA_WIDTH, s00_axis_tlast  in  1: raw DMA stream (A words then B words, row-major).
REQ-005 SHALL have the ports m00_axis_tvalid  out  1, m00_axis_tready  in  1, m00_axis_tdata  out  DATA_WIDTH, m00_axis_tlast  out  1: framed stream to the multiplier slave port.
REQ-006 SHALL have the ports sel  out  1 (0=matrix A, 1=matrix B) and start  out  1 (one-cycle multiply start pulse).
REQ-007 SHALL have the ports res_tvalid  in  1, res_tready  in  1, res_tlast  in  1: monitor taps of the multiplier result stream.
REQ-008 SHALL have the ports busy  out  1 (not in LOAD_A), err_tlast  out  1 (sticky tlast mismatch), err_cnt  out  8 (mismatch count).

Function
REQ-009 SHALL implement FSM states LOAD_A, LOAD_B, START, WAIT_RES; reset state LOAD_A.
REQ-010 SHALL pass data through a 2-entry skid buffer: s00_axis_tready = buffer not full; sustained 1 word/cycle when m00_axis_tready=1; no loss or duplication under any tready pattern.
REQ-011 SHALL keep m00_axis_tvalid/tdata/tlast stable while m00_axis_tvalid=1 and m00_axis_tready=0.
REQ-012 SHALL count output handshakes (m00 tvalid&tready) in a SIZE_LOG-bit word counter, wrapping SIZE-1 -> 0.
REQ-013 SHALL assert m00_axis_tlast on word SIZE-1 of each matrix, independent of s00_axis_tlast.
REQ-014 SHALL transition LOAD_A -> LOAD_B on the handshake of word SIZE-1 while sel=0; sel SHALL change to 1 on the following cycle.
REQ-015 SHALL transition LOAD_B -> START on handshake of word SIZE-1 while sel=1; START SHALL last exactly one cycle with start=1, then go to WAIT_RES.
REQ-016 SHALL hold s00_axis_tready=0 and m00_axis_tvalid=0 in START and WAIT_RES; buffered words SHALL be retained.
REQ-017 SHALL transition WAIT_RES -> LOAD_A, with sel=0, the cycle after res_tvalid&res_tready&res_tlast.
REQ-018 SHALL treat an input tlast on a word other than SIZE-1, or missing on word SIZE-1, as a mismatch (under REQ-024); the framing counter SHALL NOT resynchronise.
REQ-019 SHALL saturate err_cnt at 255; err_tlast SHALL clear only on reset.
REQ-020 SHALL handle simultaneous input acceptance and output handshake in the same cycle with no change in buffer occupancy.

Reset
REQ-021 SHALL on reset (any cycle, including mid-matrix) force: state LOAD_A, counter 0, buffer empty, sel=0, start=0, busy=0, s00_axis_tready=0 while reset is asserted, m00_axis_tvalid=0, m00_axis_tlast=0, err_tlast=0, err_cnt=0.
REQ-022 SHALL assert s00_axis_tready=1 on the first clock edge after reset deassertion.
REQ-023 SHALL not reset the data registers; their contents are don't-care while tvalid=0.

Configuration
REQ-024 SHALL, when macro MAT_FRAMER_TLAST_CHECK_EN is defined, implement REQ-018/019 mismatch detection; when undefined, s00_axis_tlast SHALL be ignored, err_tlast=0 and err_cnt=0 constantly.

Verification
REQ-025 SHALL cover: DIM_LOG=2, 32 words 1..32 with tready=1 -> words 1..16 out with sel=0 and tlast on 16, words 17..32 with sel=1 and tlast on 32, start=1 for exactly 1 cycle.
REQ-026 SHALL cover: random m00_axis_tready (50%) over 32 words -> output sequence 1..32 identical, no stalls on tdata while tvalid=1.
REQ-027 SHALL cover: WAIT_RES with 3 further input words presented -> s00_axis_tready=0 until res_tlast handshake; then words forwarded in order with sel=0.
REQ-028 SHALL cover: input tlast on word 5 (DIM_LOG=2), macro defined -> err_tlast=1, err_cnt=1, output tlast still on word 16; macro undefined -> err_tlast=0.
REQ-029 SHALL cover: reset asserted after word 7 of B -> next cycle sel=0, m00_axis_tvalid=0, busy=0; a fresh 32-word load completes normally.
REQ-030 SHALL cover: 300 mismatches -> err_cnt=255.
